reg_xfer_seq: RTL

REG_XFER_SEQ -- requirements
Module: reg_xfer_seq

---
 rtl/reg_xfer_seq_pkg.sv | 38 +++
 rtl/reg_xfer_seq_if.sv | 23 ++
 rtl/reg_xfer_seq.sv | 82 ++++++++
 3 files changed

// File: rtl/reg_xfer_seq_pkg.sv
// reg_xfer_seq_pkg: shared op types and per-register half-op decode for the transfer sequencer
package reg_xfer_seq_pkg;
    typedef enum logic [1:0] {REG_OP_NONE = 2'd0, REG_OP_READ = 2'd1, REG_OP_WRITE = 2'd2} reg_op_t;
    typedef enum logic [2:0] {XFER_MOV = 3'd0, XFER_SWAPH = 3'd1, XFER_SAVE = 3'd2, XFER_RESTORE = 3'd3} xfer_op_t;
    typedef enum logic [2:0] {ST_IDLE, ST_STEP1, ST_STEP2, ST_STEP3, ST_ERR} state_t;
    typedef struct packed {
        reg_op_t lo;
        reg_op_t hi;
    } half_ops_t;

    function automatic state_t last_step(xfer_op_t op, logic [2:0] src, logic [2:0] dst);
        return (op == XFER_SWAPH) ? ((src == dst) ? ST_STEP3 : ST_STEP2) : ST_STEP1;
    endfunction

    // WRITE drives a half onto the shared lanes, READ loads from them
    function automatic half_ops_t half_ops(state_t st, xfer_op_t op, logic [2:0] src, logic [2:0] dst,
                                           logic [2:0] r, logic [2:0] scratch);
        half_ops_t h;
        h = '{REG_OP_NONE, REG_OP_NONE};
        if (op == XFER_MOV && st == ST_STEP1) begin
            if (r == src) h = '{REG_OP_WRITE, REG_OP_WRITE};
            else if (r == dst) h = '{REG_OP_READ, REG_OP_READ};
        end else if (op == XFER_SWAPH && src != dst) begin
            if (st == ST_STEP1 && r == src) h.lo = REG_OP_WRITE;
            if (st == ST_STEP1 && r == dst) h.hi = REG_OP_READ;
            if (st == ST_STEP2 && r == src) h.hi = REG_OP_WRITE;
            if (st == ST_STEP2 && r == dst) h.lo = REG_OP_READ;
        end else if (op == XFER_SWAPH) begin
            if (st == ST_STEP1 && r == src) h = '{REG_OP_WRITE, REG_OP_WRITE};
            else if (st == ST_STEP1 && r == scratch) h = '{REG_OP_READ, REG_OP_READ};
            if (st == ST_STEP2 && r == scratch) h.lo = REG_OP_WRITE;
            if (st == ST_STEP2 && r == dst) h.hi = REG_OP_READ;
            if (st == ST_STEP3 && r == scratch) h.hi = REG_OP_WRITE;
            if (st == ST_STEP3 && r == dst) h.lo = REG_OP_READ;
        end
        return h;
    endfunction
endpackage

// File: rtl/reg_xfer_seq_if.sv
// reg_xfer_seq_if: command handshake and per-register op bus of the transfer sequencer
interface reg_xfer_seq_if import reg_xfer_seq_pkg::*; #(parameter int NUM_REGS = 4);
    logic     cmd_valid;
    logic     cmd_ready;
    xfer_op_t cmd_op;
    logic [2:0] cmd_src;
    logic [2:0] cmd_dst;
    reg_op_t  op_low [NUM_REGS];
    reg_op_t  op_high [NUM_REGS];
    logic     save;
    logic     restore;
    logic     done;
    logic     err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst,
        input  cmd_ready, op_low, op_high, save, restore, done, err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst,
        output cmd_ready, op_low, op_high, save, restore, done, err
    );
endinterface

// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq: sequences split-register half ops for MOV, SWAPH, SAVE and RESTORE commands
module reg_xfer_seq import reg_xfer_seq_pkg::*; #(
    parameter int NUM_REGS = 4,
    parameter int SCRATCH  = NUM_REGS - 1
) (
    input logic clk,
    input logic rst_n,
    reg_xfer_seq_if.slave bus
);
    localparam logic [3:0] NR = 4'(NUM_REGS);
    localparam logic [2:0] SC = 3'(SCRATCH);

    state_t     state, state_n;
    xfer_op_t   op_q, op_n;
    logic [2:0] src_q, dst_q, src_n, dst_n;
    logic       accept, illegal;
    half_ops_t  h;
    reg_op_t    low_n [NUM_REGS];
    reg_op_t    high_n [NUM_REGS];

    assign accept  = bus.cmd_valid && bus.cmd_ready;
    assign illegal = bus.cmd_op > XFER_RESTORE
                  || (bus.cmd_op inside {XFER_MOV, XFER_SWAPH}
                      && ({1'b0, bus.cmd_src} >= NR || {1'b0, bus.cmd_dst} >= NR))
                  || (bus.cmd_op == XFER_SWAPH && bus.cmd_src == bus.cmd_dst && bus.cmd_src == SC);

    always_comb begin
        state_n = state;
        op_n    = op_q;
        src_n   = src_q;
        dst_n   = dst_q;
        if (state == ST_IDLE && accept) begin
            op_n    = bus.cmd_op;
            src_n   = bus.cmd_src;
            dst_n   = bus.cmd_dst;
            state_n = illegal ? ST_ERR : ST_STEP1;
        end else if (state inside {ST_STEP1, ST_STEP2, ST_STEP3}) begin
            state_n = (state == last_step(op_q, src_q, dst_q)) ? ST_IDLE
                    : (state == ST_STEP1) ? ST_STEP2 : ST_STEP3;
        end else if (state == ST_ERR) begin
            state_n = ST_IDLE;
        end
    end

    // outputs are precomputed from the next state so they register alongside it
    always_comb begin
        h = '{REG_OP_NONE, REG_OP_NONE};
        for (int i = 0; i < NUM_REGS; i++) begin
            h         = half_ops(state_n, op_n, src_n, dst_n, 3'(i), SC);
            low_n[i]  = h.lo;
            high_n[i] = h.hi;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_q        <= XFER_MOV;
            src_q       <= '0;
            dst_q       <= '0;
            bus.cmd_ready <= 1'b0;
            bus.op_low  <= '{default: REG_OP_NONE};
            bus.op_high <= '{default: REG_OP_NONE};
            bus.save    <= 1'b0;
            bus.restore <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            state       <= state_n;
            op_q        <= op_n;
            src_q       <= src_n;
            dst_q       <= dst_n;
            bus.cmd_ready <= state_n == ST_IDLE;
            bus.op_low  <= low_n;
            bus.op_high <= high_n;
            bus.save    <= state_n == ST_STEP1 && op_n == XFER_SAVE;
            bus.restore <= state_n == ST_STEP1 && op_n == XFER_RESTORE;
            bus.done    <= state_n == last_step(op_n, src_n, dst_n);
            bus.err     <= state_n == ST_ERR;
        end
    end
endmodule
